// File: rtl/hit_pkg.sv
// Shared types and constants for the hit detector.
// Optional build macro used by this slice: HIT_SYNC_EN (button synchronizer).
package hit_pkg;

  // Width of the LED / button vectors (one bit per LED).
  localparam int LED_W = 8;

  // Round-tracking states; the encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/hit_detector_if.sv
// Bus bundle for the hit detector: round/target/button inputs and the
// score outputs. The master side drives the round stimulus, the slave
// side (the detector) returns pulses, counters and debug state.
interface hit_detector_if
  import hit_pkg::*;
#(
  parameter int SCORE_W = 8
);

  logic               freq;
  logic [LED_W-1:0]   LED_num;
  logic [LED_W-1:0]   btn;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] hits;
  logic [SCORE_W-1:0] misses;
  logic [1:0]         state;

  modport master (
    output freq, LED_num, btn,
    input  hit, miss, hits, misses, state
  );

  modport slave (
    input  freq, LED_num, btn,
    output hit, miss, hits, misses, state
  );

endinterface

// File: rtl/hit_detector_btn_edge.sv
// Button conditioning: optional 2-flop synchronizer followed by a
// per-bit rising-edge detector. Define HIT_SYNC_EN to insert the
// synchronizer (adds two cycles before the edge is seen).
module btn_edge
  import hit_pkg::*;
#(
  parameter int W = LED_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] btn_e_o
);

  logic [W-1:0] btn_s;

`ifdef HIT_SYNC_EN
  logic [W-1:0] sync1_d, sync1_q;
  logic [W-1:0] sync2_d, sync2_q;

  // Two-stage shift of the raw button levels.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared by reset so no stale level survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn_i;
`endif

  logic [W-1:0] prev_d, prev_q;

  // Remember the previous conditioned level for edge detection.
  always_comb begin
    prev_d = btn_s;
  end

  // Previous-level flop; reset to zero so a button already held after
  // reset reads as a fresh edge (harmless, the FSM is idle then).
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // A press is a 0->1 transition on any bit.
  assign btn_e_o = btn_s & ~prev_q;

endmodule

// File: rtl/hit_detector.sv
// Hit detector: judges each player press against the target LED of the
// current round and keeps saturating hit/miss scores.
// Build option: define HIT_SYNC_EN to synchronize the buttons (3-cycle
// press-to-pulse latency instead of 1).
module hit_detector
  import hit_pkg::*;
#(
  parameter int SCORE_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  hit_detector_if.slave  bus
);

  // Saturating increment: sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  logic [LED_W-1:0] btn_e;

  btn_edge #(
    .W (LED_W)
  ) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.btn),
    .btn_e_o (btn_e)
  );

  state_t             state_d,  state_q;
  logic               hit_d,    hit_q;
  logic               miss_d,   miss_q;
  logic [SCORE_W-1:0] hits_d,   hits_q;
  logic [SCORE_W-1:0] misses_d, misses_q;
  logic               blank_d,  blank_q;
  logic               press;

  // A press only counts outside the blanking cycle that follows a freq,
  // and never in a freq cycle (the round boundary takes priority).
  assign press = (btn_e != '0) && !blank_q && !bus.freq;

  // Next-state, pulse and score computation.
  always_comb begin
    state_d  = state_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    hits_d   = hits_q;
    misses_d = misses_q;
    blank_d  = bus.freq;
    unique case (state_q)
      IDLE: begin
        if (bus.freq) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.freq) begin
          // Round ended without a press: timeout miss, stay armed.
          miss_d   = 1'b1;
          misses_d = sat_inc(misses_q);
        end else if (press) begin
          if (btn_e == bus.LED_num) begin
            hit_d  = 1'b1;
            hits_d = sat_inc(hits_q);
          end else begin
            miss_d   = 1'b1;
            misses_d = sat_inc(misses_q);
          end
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.freq) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and registered outputs; reset wins over any same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      blank_q  <= blank_d;
    end
  end

  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
  assign bus.hits   = hits_q;
  assign bus.misses = misses_q;
  assign bus.state  = state_q;

endmodule
